// File: rtl/ofdm_symbol_scheduler.sv
// OFDM symbol scheduler: walks N_FFT slots per symbol, classifies each slot as
// null/data/pilot and pulls QAM or pilot samples through zero-latency handshakes.
module ofdm_symbol_scheduler #(
    parameter int N_FFT         = 2048,
    parameter int IDX_W         = 11,
    parameter int GUARD_LO      = 108,
    parameter int GUARD_HI      = 107,
    parameter int PILOT_SPACING = 12,
    parameter int PILOT_OFFSET  = 1,
    parameter int N_SYM         = 14,
    parameter int GAP_CYCLES    = 4
) (
    input  logic             clk,
    input  logic             res,
    input  logic             en,
    input  logic             start,
    input  logic             valid_qam,
    input  logic             valid_pilot,
    input  logic             out_ready,
    output logic             take_qam,
    output logic             take_pilot,
    output logic             out_valid,
    output logic [1:0]       sel,
    output logic [IDX_W-1:0] index,
    output logic             sop,
    output logic             eop,
    output logic [3:0]       sym_idx,
    output logic             frame_done,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYM  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam int PH_W  = $clog2(PILOT_OFFSET + PILOT_SPACING + 1);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_FFT - 1);
    localparam logic [IDX_W-1:0] DC_IDX    = IDX_W'(N_FFT / 2);
    localparam logic [IDX_W-1:0] GLO_END   = IDX_W'(GUARD_LO);
    localparam logic [IDX_W-1:0] GHI_START = IDX_W'(N_FFT - GUARD_HI);
    localparam logic [PH_W-1:0]  PH_START  = PH_W'(PILOT_OFFSET);
    localparam logic [PH_W-1:0]  PH_RELOAD = PH_W'(PILOT_SPACING - 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [3:0]       SYM_LAST  = 4'(N_SYM - 1);

    state_t           state_r, state_s;
    logic [IDX_W-1:0] index_r, index_s;
    logic [3:0]       sym_r, sym_s;
    logic [GAP_W-1:0] gap_r, gap_s;
    logic [PH_W-1:0]  phase_r, phase_s;
    logic             frame_done_r, frame_done_s;
    logic             null_s, out_valid_s, accept_s, sop_s, eop_s;
    logic [1:0]       sel_s;

    // Slot classification, handshake and next-state logic.
    always_comb begin
        state_s      = state_r;
        index_s      = index_r;
        sym_s        = sym_r;
        gap_s        = gap_r;
        phase_s      = phase_r;
        frame_done_s = 1'b0;

        null_s = (index_r < GLO_END) || (index_r >= GHI_START) || (index_r == DC_IDX);
        // phase_r counts slots down to the next pilot position; zero means this slot.
        if (null_s) begin
            sel_s = 2'd0;
        end else if (phase_r == {PH_W{1'b0}}) begin
            sel_s = 2'd2;
        end else begin
            sel_s = 2'd1;
        end

        case (sel_s)
            2'd0:    out_valid_s = (state_r == ST_SYM);
            2'd1:    out_valid_s = (state_r == ST_SYM) && valid_qam;
            2'd2:    out_valid_s = (state_r == ST_SYM) && valid_pilot;
            default: out_valid_s = 1'b0;
        endcase

        accept_s = en && out_valid_s && out_ready;
        sop_s    = accept_s && (index_r == {IDX_W{1'b0}});
        eop_s    = accept_s && (index_r == LAST_IDX);

        case (state_r)
            ST_IDLE: begin
                if (start && !frame_done_r) begin
                    state_s = ST_SYM;
                    index_s = {IDX_W{1'b0}};
                    sym_s   = 4'd0;
                    phase_s = PH_START;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SYM: begin
                if (eop_s) begin
                    index_s = {IDX_W{1'b0}};
                    phase_s = PH_START;
                    gap_s   = {GAP_W{1'b0}};
                    if (sym_r == SYM_LAST) begin
                        state_s      = ST_IDLE;
                        sym_s        = 4'd0;
                        frame_done_s = 1'b1;
                    end else begin
                        sym_s   = sym_r + 4'd1;
                        state_s = (GAP_CYCLES == 0) ? ST_SYM : ST_GAP;
                    end
                end else if (accept_s) begin
                    index_s = index_r + {{(IDX_W-1){1'b0}}, 1'b1};
                    phase_s = (phase_r == {PH_W{1'b0}}) ? PH_RELOAD
                                                         : phase_r - {{(PH_W-1){1'b0}}, 1'b1};
                end else begin
                    state_s = ST_SYM;
                end
            end
            ST_GAP: begin
                if (gap_r == GAP_LAST) begin
                    state_s = ST_SYM;
                end else begin
                    gap_s = gap_r + {{(GAP_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State registers; en low freezes everything.
    always_ff @(posedge clk) begin
        if (res) begin
            state_r      <= ST_IDLE;
            index_r      <= {IDX_W{1'b0}};
            sym_r        <= 4'd0;
            gap_r        <= {GAP_W{1'b0}};
            phase_r      <= PH_START;
            frame_done_r <= 1'b0;
        end else if (en) begin
            state_r      <= state_s;
            index_r      <= index_s;
            sym_r        <= sym_s;
            gap_r        <= gap_s;
            phase_r      <= phase_s;
            frame_done_r <= frame_done_s;
        end
    end

    assign out_valid  = out_valid_s;
    assign sel        = sel_s;
    assign index      = index_r;
    assign take_qam   = accept_s && (sel_s == 2'd1);
    assign take_pilot = accept_s && (sel_s == 2'd2);
    assign sop        = sop_s;
    assign eop        = eop_s;
    assign sym_idx    = sym_r;
    assign frame_done = frame_done_r;
    assign busy       = (state_r != ST_IDLE);

endmodule

// File: tb/tb_ofdm_symbol_scheduler.sv
// Self-checking bench for ofdm_symbol_scheduler: directed scenarios plus random
// stimulus, all outputs compared every cycle against a slot-level behavioural model.
module tb_ofdm_symbol_scheduler;
    localparam int N_FFT = 16, IDX_W = 4, GLO = 2, GHI = 1, PSP = 4, POFF = 1;
    localparam int NSYM = 2, GAPC = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic res, en, start, valid_qam, valid_pilot, out_ready;
    logic take_qam, take_pilot, out_valid, sop, eop, frame_done, busy;
    logic [1:0] sel;
    logic [IDX_W-1:0] index;
    logic [3:0] sym_idx;

    ofdm_symbol_scheduler #(
        .N_FFT(N_FFT), .IDX_W(IDX_W), .GUARD_LO(GLO), .GUARD_HI(GHI),
        .PILOT_SPACING(PSP), .PILOT_OFFSET(POFF), .N_SYM(NSYM), .GAP_CYCLES(GAPC)
    ) dut (
        .clk(clk), .res(res), .en(en), .start(start), .valid_qam(valid_qam),
        .valid_pilot(valid_pilot), .out_ready(out_ready), .take_qam(take_qam),
        .take_pilot(take_pilot), .out_valid(out_valid), .sel(sel), .index(index),
        .sop(sop), .eop(eop), .sym_idx(sym_idx), .frame_done(frame_done), .busy(busy)
    );

    int n_vec = 0, n_err = 0;
    bit chk_on = 1'b0;

    // model: mode 0=idle 1=symbol 2=gap
    int m_mode = 0, m_pos = 0, m_sym = 0, m_gap = 0;
    bit m_fd = 1'b0;

    int cyc = 0, cnt_tq = 0, cnt_tp = 0, cnt_sop = 0, cnt_eop = 0, cnt_fd = 0;
    int last_eop_cyc = 0, gap_seen = 0, fd_cyc = 0;
    int obs_sel [N_FFT];
    int exp_tab [N_FFT] = '{0,0,1,1,1,2,1,1,0,2,1,1,1,2,1,0};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int sel_of(input int i);
        if (i < GLO || i >= N_FFT - GHI || i == N_FFT / 2) return 0;
        if (i >= POFF && (i - POFF) % PSP == 0) return 2;
        return 1;
    endfunction

    // Compare DUT against model, then advance the model across the coming edge.
    always @(negedge clk) begin : compare
        int s;
        bit ov, acc, fd_old;
        s   = sel_of(m_pos);
        ov  = (m_mode == 1) && (s == 0 || (s == 1 && valid_qam) || (s == 2 && valid_pilot));
        acc = en && ov && out_ready;
        if (chk_on) begin
            chk("busy", busy, m_mode != 0);
            chk("sel", sel, s);
            chk("index", index, m_pos);
            chk("sym_idx", sym_idx, m_sym);
            chk("frame_done", frame_done, m_fd);
            chk("out_valid", out_valid, ov);
            chk("take_qam", take_qam, acc && s == 1);
            chk("take_pilot", take_pilot, acc && s == 2);
            chk("sop", sop, acc && m_pos == 0);
            chk("eop", eop, acc && m_pos == N_FFT - 1);
            cyc++;
            if (take_qam === 1'b1) cnt_tq++;
            if (take_pilot === 1'b1) cnt_tp++;
            if (frame_done === 1'b1) begin cnt_fd++; fd_cyc = cyc; end
            if (sop === 1'b1) begin
                cnt_sop++;
                if (cnt_eop > 0) gap_seen = cyc - last_eop_cyc;
            end
            if (eop === 1'b1) begin cnt_eop++; last_eop_cyc = cyc; end
            if (acc) obs_sel[m_pos] = int'(sel);
        end
        fd_old = m_fd;
        if (res) begin
            m_mode = 0; m_pos = 0; m_sym = 0; m_gap = 0; m_fd = 1'b0;
        end else if (en) begin
            m_fd = 1'b0;
            if (m_mode == 0) begin
                if (start && !fd_old) begin m_mode = 1; m_pos = 0; m_sym = 0; end
            end else if (m_mode == 1) begin
                if (acc) begin
                    if (m_pos == N_FFT - 1) begin
                        m_pos = 0;
                        if (m_sym == NSYM - 1) begin
                            m_mode = 0; m_sym = 0; m_fd = 1'b1;
                        end else begin
                            m_sym++;
                            m_gap = GAPC;
                            m_mode = (GAPC == 0) ? 1 : 2;
                        end
                    end else begin
                        m_pos++;
                    end
                end
            end else begin
                m_gap--;
                if (m_gap == 0) m_mode = 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic wait_idx(input int target, input int budget);
        for (int k = 0; k < budget; k++) begin
            tick();
            if (index == IDX_W'(target)) return;
        end
        n_vec++; n_err++;
        $display("FAIL wait_idx: got timeout, expected index %0d", target);
    endtask

    task automatic wait_done(input int budget);
        for (int k = 0; k < budget; k++) begin
            tick();
            if (frame_done === 1'b1) begin tick(); return; end
        end
        n_vec++; n_err++;
        $display("FAIL wait_done: got timeout, expected frame_done");
    endtask

    initial begin
        int b_tq, b_tp, b_sop, b_eop, b_fd;
        res = 1'b1; en = 1'b1; start = 1'b0;
        valid_qam = 1'b1; valid_pilot = 1'b1; out_ready = 1'b1;
        tick();
        chk_on = 1'b1;
        tick();
        res = 1'b0;
        chk("rst_index", index, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sel", sel, 0);
        chk("rst_frame_done", frame_done, 0);

        // model pinned against hand-computed slot map
        for (int i = 0; i < N_FFT; i++) chk("model_sel", sel_of(i), exp_tab[i]);

        // full frame, all sources valid
        b_tq = cnt_tq; b_tp = cnt_tp; b_sop = cnt_sop; b_eop = cnt_eop; b_fd = cnt_fd;
        pulse_start();
        wait_done(100);
        chk("frame_take_qam", cnt_tq - b_tq, 18);
        chk("frame_take_pilot", cnt_tp - b_tp, 6);
        chk("frame_sop", cnt_sop - b_sop, 2);
        chk("frame_eop", cnt_eop - b_eop, 2);
        chk("frame_done_pulses", cnt_fd - b_fd, 1);
        chk("gap_len", gap_seen, GAPC + 1);
        chk("fd_after_eop", fd_cyc - last_eop_cyc, 1);
        for (int i = 0; i < N_FFT; i++) chk("sel_seq", obs_sel[i], exp_tab[i]);

        // valid_qam stall: nulls pass, data waits
        valid_qam = 1'b0;
        b_tq = cnt_tq;
        pulse_start();
        repeat (5) tick();
        chk("stall_null_pass", index, 2);
        valid_qam = 1'b1;
        wait_idx(3, 20);
        valid_qam = 1'b0;
        b_tq = cnt_tq;
        repeat (5) tick();
        chk("stall_index", index, 3);
        chk("stall_no_take", cnt_tq - b_tq, 0);
        valid_qam = 1'b1;
        wait_done(100);

        // out_ready toggling
        b_tq = cnt_tq; b_tp = cnt_tp;
        pulse_start();
        for (int k = 0; k < 60; k++) begin out_ready = ~out_ready; tick(); end
        out_ready = 1'b1;
        wait_done(100);
        chk("toggle_take_qam", cnt_tq - b_tq, 18);
        chk("toggle_take_pilot", cnt_tp - b_tp, 6);

        // reset mid-symbol
        pulse_start();
        wait_idx(9, 30);
        res = 1'b1; tick(); res = 1'b0;
        chk("abort_index", index, 0);
        chk("abort_busy", busy, 0);
        b_eop = cnt_eop; b_fd = cnt_fd; b_sop = cnt_sop;
        repeat (5) tick();
        chk("abort_no_eop", cnt_eop - b_eop, 0);
        chk("abort_no_fd", cnt_fd - b_fd, 0);
        pulse_start();
        tick();
        chk("replay_sop", cnt_sop - b_sop, 1);
        wait_done(100);

        // en low mid-symbol with start while busy
        b_eop = cnt_eop;
        pulse_start();
        wait_idx(5, 30);
        en = 1'b0; start = 1'b1;
        repeat (3) begin tick(); chk("en_low_hold", index, 5); end
        en = 1'b1; tick(); start = 1'b0;
        wait_done(100);
        chk("en_frame_eop", cnt_eop - b_eop, 2);

        // randomized stimulus
        for (int k = 0; k < 3000; k++) begin
            res         = ($urandom_range(0, 99) == 0);
            en          = ($urandom_range(0, 9) != 0);
            start       = ($urandom_range(0, 7) == 0);
            valid_qam   = ($urandom_range(0, 3) != 0);
            valid_pilot = ($urandom_range(0, 3) != 0);
            out_ready   = ($urandom_range(0, 3) != 0);
            tick();
        end
        res = 1'b0; en = 1'b1; start = 1'b0;
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
